// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_ctrl
// Description : 32-bit load/store bridge to a 16-bit asynchronous SRAM; each
//               word is moved as two half-word accesses (low half, then high).
// Revision    : 1.0 - initial release
// ============================================================================
module sram_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n,
    output logic        sram_oe_n,
    output logic        sram_ce_n
);

    localparam logic [3:0] c_last_cnt = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_next;

    logic        r_is_wr;
    logic [15:0] r_wdata_hi;
    logic [31:0] r_read_data;
    logic [17:0] r_sram_addr;
    logic [15:0] r_sram_dq_out;
    logic        r_sram_dq_oe;
    logic        r_sram_we_n;
    logic        r_sram_oe_n;
    logic        r_sram_ce_n;

    logic        w_req;
    logic        w_start;
    logic        w_last;
    logic        w_access;
    logic        w_op_wr;
    logic [31:0] w_offset;
    logic        w_unused_offset;

    assign w_req    = rd_en | wr_en;
    assign w_start  = (r_state == ST_IDLE) & w_req;
    assign w_last   = (r_cnt == c_last_cnt);
    assign w_offset = address - BASE_ADDR;
    // Only the 17-bit word index reaches the SRAM; upper bits wrap silently.
    assign w_unused_offset = ^{w_offset[31:19], w_offset[1:0]};

    assign ready = ~w_req | (r_state == ST_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = 4'd0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_next_state = ST_LOW;
                end
            end
            ST_LOW: begin
                if (w_last) begin
                    w_next_state = ST_HIGH;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            ST_HIGH: begin
                if (w_last) begin
                    w_next_state = ST_DONE;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Strobes are computed from the next state so the registered pins line up with LOW/HIGH.
    assign w_access = (w_next_state == ST_LOW) | (w_next_state == ST_HIGH);
    assign w_op_wr  = w_start ? wr_en : r_is_wr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_is_wr       <= 1'b0;
            r_wdata_hi    <= 16'd0;
            r_read_data   <= 32'd0;
            r_sram_addr   <= 18'd0;
            r_sram_dq_out <= 16'd0;
            r_sram_dq_oe  <= 1'b0;
            r_sram_we_n   <= 1'b1;
            r_sram_oe_n   <= 1'b1;
            r_sram_ce_n   <= 1'b1;
        end else begin
            r_sram_ce_n  <= ~w_access;
            r_sram_we_n  <= ~(w_access & w_op_wr);
            r_sram_oe_n  <= ~(w_access & ~w_op_wr);
            r_sram_dq_oe <= w_access & w_op_wr;

            if (w_start) begin
                r_is_wr     <= wr_en;
                r_wdata_hi  <= write_data[31:16];
                r_sram_addr <= {w_offset[18:2], 1'b0};
                if (wr_en) begin
                    r_sram_dq_out <= write_data[15:0];
                end
            end

            if ((r_state == ST_LOW) && w_last) begin
                r_sram_addr[0] <= 1'b1;
                if (r_is_wr) begin
                    r_sram_dq_out <= r_wdata_hi;
                end else begin
                    r_read_data[15:0] <= sram_dq_in;
                end
            end

            if ((r_state == ST_HIGH) && w_last && !r_is_wr) begin
                r_read_data[31:16] <= sram_dq_in;
            end
        end
    end

    assign read_data   = r_read_data;
    assign sram_addr   = r_sram_addr;
    assign sram_dq_out = r_sram_dq_out;
    assign sram_dq_oe  = r_sram_dq_oe;
    assign sram_we_n   = r_sram_we_n;
    assign sram_oe_n   = r_sram_oe_n;
    assign sram_ce_n   = r_sram_ce_n;

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_ctrl
// Description : Self-checking bench for sram_ctrl with a behavioural SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_ctrl;

    localparam logic [31:0] BASE = 32'd1024;
    localparam int          WAIT = 2;
    localparam int          LAT  = 2 * WAIT + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] address = 32'd0;
    logic [31:0] write_data = 32'd0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;
    logic        sram_oe_n;
    logic        sram_ce_n;

    int n_chk  = 0;
    int n_pass = 0;

    sram_ctrl #(.BASE_ADDR(BASE), .WAIT_CYCLES(WAIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_in (sram_dq_in),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n),
        .sram_ce_n  (sram_ce_n)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM: write latched at the clock edge, read combinational.
    logic [15:0] sram_mem [0:262143];
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) sram_mem[sram_addr] <= sram_dq_out;
    end
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr] : 16'h0000;

    // Reference model: half-word store keyed by SRAM half address.
    logic [15:0] ref_mem [int];
    logic [31:0] exp_rd = 32'd0;

    function automatic int ref_half(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'((off / 32'd4) % 32'd131072) * 2;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int h;
        logic [15:0] lo, hi;
        h  = ref_half(a);
        lo = ref_mem.exists(h)     ? ref_mem[h]     : 16'h0000;
        hi = ref_mem.exists(h + 1) ? ref_mem[h + 1] : 16'h0000;
        return {hi, lo};
    endfunction

    task automatic ref_access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        int h;
        h = ref_half(a);
        if (wr) begin
            ref_mem[h]     = d[15:0];
            ref_mem[h + 1] = d[31:16];
        end else if (rd) begin
            exp_rd = ref_word(a);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    // Called just after a rising edge; returns just after the edge that ends DONE.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] d, input bit hold,
                              output int low_cyc, output int idle_cyc,
                              output logic [31:0] rdata, output logic [17:0] lo,
                              output logic [17:0] hi, output bit oe_seen);
        bit done  = 0;
        bit first = 1;
        rd_en = rd; wr_en = wr; address = a; write_data = d;
        low_cyc = 0; idle_cyc = 0; oe_seen = 0; lo = '0; hi = '0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (ready) begin
                done = 1;
                break;
            end
            low_cyc++;
            if (sram_dq_oe) oe_seen = 1;
            if (!sram_ce_n) begin
                if (first) lo = sram_addr;
                hi = sram_addr;
                first = 0;
            end else begin
                idle_cyc++;
            end
        end
        if (!done) chk("ready_timeout", 32'd0, 32'd1);
        rdata = read_data;
        @(posedge clk);
        #1;
        if (!hold) begin
            rd_en = 1'b0;
            wr_en = 1'b0;
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [17:0] exp_lo;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int          lc, ic;
        logic [31:0] rdv;
        logic [17:0] lo, hi;
        bit          oes;
        logic [31:0] written[$];

        vecs[0] = '{1'b0, 1'b1, 32'd1024, 32'h12345678, 32'h00000000, 18'h00000};
        vecs[1] = '{1'b1, 1'b0, 32'd1024, 32'h00000000, 32'h12345678, 18'h00000};
        vecs[2] = '{1'b0, 1'b1, 32'd1028, 32'hCAFEBABE, 32'h12345678, 18'h00002};
        vecs[3] = '{1'b1, 1'b0, 32'd1028, 32'h00000000, 32'hCAFEBABE, 18'h00002};
        vecs[4] = '{1'b0, 1'b1, 32'd1020, 32'hDEADBEEF, 32'hCAFEBABE, 18'h3FFFE};
        vecs[5] = '{1'b1, 1'b0, 32'd1020, 32'h00000000, 32'hDEADBEEF, 18'h3FFFE};
        vecs[6] = '{1'b1, 1'b1, 32'd1032, 32'hA5A5A5A5, 32'hDEADBEEF, 18'h00004};
        vecs[7] = '{1'b1, 1'b0, 32'd1032, 32'h00000000, 32'hA5A5A5A5, 18'h00004};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_sram_addr", {14'd0, sram_addr}, 32'd0);
        chk("rst_dq_out", {16'd0, sram_dq_out}, 32'd0);
        chk("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        chk("rst_ctrl_n", {29'd0, sram_we_n, sram_oe_n, sram_ce_n}, 32'd7);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors
        foreach (vecs[i]) begin
            run_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, lc, ic, rdv, lo, hi, oes);
            ref_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("v%0d_latency", i), lc, LAT);
            chk($sformatf("v%0d_idle", i), ic, 1);
            chk($sformatf("v%0d_lo_addr", i), {14'd0, lo}, {14'd0, vecs[i].exp_lo});
            chk($sformatf("v%0d_hi_addr", i), {14'd0, hi}, {14'd0, vecs[i].exp_lo | 18'd1});
            chk($sformatf("v%0d_dq_oe", i), {31'd0, oes}, {31'd0, vecs[i].wr});
            chk($sformatf("v%0d_read_data", i), rdv, vecs[i].exp_rdata);
            if (vecs[i].wr) begin
                chk($sformatf("v%0d_mem_lo", i), {16'd0, sram_mem[vecs[i].exp_lo]}, {16'd0, vecs[i].wdata[15:0]});
                chk($sformatf("v%0d_mem_hi", i), {16'd0, sram_mem[vecs[i].exp_lo | 18'd1]}, {16'd0, vecs[i].wdata[31:16]});
            end
        end

        // Back-to-back: write held across DONE, then read
        run_access(1'b0, 1'b1, 32'd1040, 32'h0BADF00D, 1'b1, lc, ic, rdv, lo, hi, oes);
        ref_access(1'b0, 1'b1, 32'd1040, 32'h0BADF00D);
        run_access(1'b1, 1'b0, 32'd1040, 32'h0, 1'b0, lc, ic, rdv, lo, hi, oes);
        ref_access(1'b1, 1'b0, 32'd1040, 32'h0);
        chk("b2b_latency", lc, LAT);
        chk("b2b_idle", ic, 1);
        chk("b2b_read_data", rdv, 32'h0BADF00D);

        // Reset during HIGH of a read
        rd_en = 1'b1; wr_en = 1'b0; address = 32'd1024;
        repeat (4) @(negedge clk);
        chk("pre_rst_oe_n", {31'd0, sram_oe_n}, 32'd0);
        chk("pre_rst_addr", {14'd0, sram_addr}, 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_read_data", read_data, 32'd0);
        chk("mid_rst_sram_addr", {14'd0, sram_addr}, 32'd0);
        chk("mid_rst_dq_out", {16'd0, sram_dq_out}, 32'd0);
        chk("mid_rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        chk("mid_rst_ctrl_n", {29'd0, sram_we_n, sram_oe_n, sram_ce_n}, 32'd7);
        rd_en = 1'b0;
        exp_rd = 32'd0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_access(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, lc, ic, rdv, lo, hi, oes);
        ref_access(1'b1, 1'b0, 32'd1028, 32'h0);
        chk("post_rst_latency", lc, LAT);
        chk("post_rst_read_data", rdv, exp_rd);

        // Randomized traffic against the reference model
        for (int n = 0; n < 40; n++) begin
            logic        rd, wr;
            logic [31:0] a, d;
            bit          hold;
            hold = (n != 39) && ($urandom_range(0, 1) == 1);
            if (written.size() == 0 || $urandom_range(0, 1) == 1) begin
                wr = 1'b1;
                rd = ($urandom_range(0, 3) == 0);
                a  = BASE + 32'h400 + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
                d  = $urandom;
                written.push_back(a);
            end else begin
                wr = 1'b0;
                rd = 1'b1;
                a  = written[$urandom_range(0, written.size() - 1)];
                d  = $urandom;
            end
            run_access(rd, wr, a, d, hold, lc, ic, rdv, lo, hi, oes);
            ref_access(rd, wr, a, d);
            chk($sformatf("rnd%0d_latency", n), lc, LAT);
            chk($sformatf("rnd%0d_read_data", n), rdv, exp_rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
